// File: rtl/axis_sa_transpose.sv
// axis_sa_transpose: buffers column-ordered R x C result tiles in a ping-pong pair of banks
// and re-emits each tile row-major, one beat per row.
module axis_sa_transpose #(
  parameter int R  = 2,
  parameter int C  = 2,
  parameter int WY = 11
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic            s_last,
  input  logic [R*WY-1:0] s_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic            m_last,
  output logic [C*WY-1:0] m_data,
  output logic            err_last
);
  localparam int CW = C > 1 ? $clog2(C) : 1;
  localparam int RW = R > 1 ? $clog2(R) : 1;
  logic [WY-1:0] bank [2][R][C];
  logic [1:0]    full, full_nxt;
  logic          wb, rb, alive, wr, rd, col_end, row_end;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  assign s_ready = alive & ~full[wb];
  assign m_valid = full[rb];
  assign m_last  = m_valid & row_end;
  assign wr      = s_valid & s_ready;
  assign rd      = m_valid & m_ready;
  assign col_end = col == CW'(C - 1);
  assign row_end = row == RW'(R - 1);
  // Fill and drain touch different banks, so both flag updates can land in one cycle.
  always_comb begin
    full_nxt = full;
    if (wr && col_end) full_nxt[wb] = 1'b1;
    if (rd && row_end) full_nxt[rb] = 1'b0;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      alive    <= 1'b0;
      full     <= '0;
      wb       <= 1'b0;
      rb       <= 1'b0;
      col      <= '0;
      row      <= '0;
      err_last <= 1'b0;
    end else begin
      alive <= 1'b1;
      full  <= full_nxt;
      if (wr) begin
        wb  <= wb ^ col_end;
        col <= col_end ? '0 : col + 1'b1;
        if (s_last != col_end) err_last <= 1'b1;
      end
      if (rd) begin
        rb  <= rb ^ row_end;
        row <= row_end ? '0 : row + 1'b1;
      end
    end
  always_ff @(posedge clk)
    if (wr) for (int r = 0; r < R; r++) bank[wb][r][col] <= s_data[r*WY +: WY];
  // Bank storage is never reset, so the output is gated to zero while no tile is ready.
  always_comb begin
    m_data = '0;
    for (int c = 0; c < C; c++) m_data[c*WY +: WY] = m_valid ? bank[rb][row][c] : '0;
  end
endmodule

// File: tb/tb_axis_sa_transpose.sv
// tb_axis_sa_transpose: directed checks of the column-to-row tile transpose with a
// queue model of the expected row beats and the bank occupancy.
module tb_axis_sa_transpose;
  localparam int R = 2, C = 2, WY = 11;
  localparam int R2 = 4, C2 = 3, WY2 = 16;

  logic clk = 0;
  always #5 clk = ~clk;

  logic            rstn = 0, s_valid = 0, s_last = 0, m_ready = 0;
  logic [R*WY-1:0] s_data = '0;
  logic            s_ready, m_valid, m_last, err_last;
  logic [C*WY-1:0] m_data;

  logic              b_rstn = 0, b_s_valid = 0, b_s_last = 0, b_m_ready = 0;
  logic [R2*WY2-1:0] b_s_data = '0;
  logic              b_s_ready, b_m_valid, b_m_last, b_err_last;
  logic [C2*WY2-1:0] b_m_data;

  axis_sa_transpose #(.R(R), .C(C), .WY(WY)) dut (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .m_data(m_data), .err_last(err_last));

  axis_sa_transpose #(.R(R2), .C(C2), .WY(WY2)) dut_b (
    .clk(clk), .rstn(b_rstn), .s_valid(b_s_valid), .s_ready(b_s_ready), .s_last(b_s_last),
    .s_data(b_s_data), .m_valid(b_m_valid), .m_ready(b_m_ready), .m_last(b_m_last),
    .m_data(b_m_data), .err_last(b_err_last));

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [21:0] pk(input logic [10:0] hi, input logic [10:0] lo);
    return {hi, lo};
  endfunction

  logic [WY-1:0]   col_buf [C][R];
  logic [C*WY:0]   exp_q [$];
  int              col_n = 0, occ = 0;

  function automatic void accept_col(input logic [R*WY-1:0] d);
    logic [C*WY:0] beat;
    for (int r = 0; r < R; r++) col_buf[col_n][r] = d[r*WY +: WY];
    col_n++;
    if (col_n == C) begin
      for (int rr = 0; rr < R; rr++) begin
        beat = '0;
        for (int c = 0; c < C; c++) beat[c*WY +: WY] = col_buf[c][rr];
        beat[C*WY] = (rr == R - 1);
        exp_q.push_back(beat);
      end
      col_n = 0;
      occ++;
    end
  endfunction

  task automatic step(input bit sv, input logic [R*WY-1:0] sd, input bit sl, input bit mr,
                      output bit acc);
    logic [C*WY:0] e;
    @(negedge clk);
    s_valid = sv; s_data = sd; s_last = sl; m_ready = mr;
    #1;
    check("s_ready_vs_occ", s_ready, occ < 2);
    check("m_valid_vs_occ", m_valid, occ > 0);
    acc = s_valid && s_ready;
    if (acc) accept_col(s_data);
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) check("spurious_beat", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("m_data", m_data, e[C*WY-1:0]);
        check("m_last", m_last, e[C*WY]);
        if (e[C*WY]) occ--;
      end
    end
  endtask

  task automatic send_col(input logic [R*WY-1:0] d, input bit sl, input int mr);
    bit acc = 0;
    for (int t = 0; t < 100 && !acc; t++)
      step(1, d, sl, mr == 2 ? bit'($urandom_range(0, 1)) : bit'(mr), acc);
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic drain();
    bit acc;
    for (int t = 0; t < 200 && exp_q.size() > 0; t++) step(0, '0, 0, 1, acc);
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic reset_a();
    @(negedge clk);
    rstn = 0; s_valid = 0; s_last = 0; m_ready = 0;
    #1;
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_data", m_data, 0);
    check("rst_err_last", err_last, 0);
    col_n = 0; occ = 0; exp_q.delete();
    @(negedge clk);
    rstn = 1;
    #1;
    check("rst_ready_before_edge", s_ready, 0);
  endtask

  function automatic logic [WY2-1:0] yb(input int r, input int c);
    return WY2'(16'h8000 + r * 256 + c);
  endfunction

  task automatic b_send(input logic [R2*WY2-1:0] d, input bit sl);
    int t = 0;
    @(negedge clk);
    b_s_valid = 1; b_s_data = d; b_s_last = sl;
    #1;
    while (!b_s_ready && t < 50) begin @(negedge clk); #1; t++; end
    if (!b_s_ready) check("b_ready_timeout", 0, 1);
    @(negedge clk);
    b_s_valid = 0; b_s_last = 0;
  endtask

  initial begin
    bit acc;
    logic [C*WY-1:0] held;
    logic [R*WY-1:0] d;
    logic [R2*WY2-1:0] bd;
    logic [C2*WY2-1:0] be;

    // 1: basic transpose and latency
    reset_a();
    step(1, pk(11'd2, 11'd1), 0, 1, acc);
    step(1, pk(11'd4, 11'd3), 1, 1, acc);
    step(0, '0, 0, 1, acc);
    check("t1_valid", m_valid, 1);
    check("t1_row0", m_data, pk(11'd3, 11'd1));
    check("t1_last0", m_last, 0);
    step(0, '0, 0, 1, acc);
    check("t1_row1", m_data, pk(11'd4, 11'd2));
    check("t1_last1", m_last, 1);
    step(0, '0, 0, 1, acc);
    check("t1_idle", m_valid, 0);

    // 2: signed extremes
    step(1, pk(11'h3FF, 11'h400), 1'b0, 1'b0, acc);
    step(1, pk(11'h000, 11'h7FF), 1'b1, 1'b0, acc);
    step(0, '0, 0, 1, acc);
    check("t2_row0", m_data, pk(11'h7FF, 11'h400));
    step(0, '0, 0, 1, acc);
    check("t2_row1", m_data, pk(11'h000, 11'h3FF));
    check("t2_err", err_last, 0);

    // 3: 50 back-to-back random tiles with random downstream stalls
    for (int i = 0; i < 50 * C; i++) begin
      d = R*WY'({$urandom, $urandom});
      send_col(d, (i % C) == C - 1, 2);
    end
    drain();

    // 4: downstream stall fills both banks, data held, then released in order
    for (int i = 0; i < 2 * C; i++) send_col(R*WY'(100 + i), (i % C) == C - 1, 0);
    step(1, R*WY'(200), 0, 0, acc);
    held = m_data;
    for (int i = 0; i < 19; i++) step(1, R*WY'(200), 0, 0, acc);
    check("t4_hold_data", m_data, held);
    check("t4_full_ready", s_ready, 0);
    check("t4_hold_valid", m_valid, 1);
    if (!acc) send_col(R*WY'(200), 0, 1);
    send_col(R*WY'(201), 1, 1);
    drain();

    // 5: s_last on column 0 sets sticky error; tile still closes on count
    send_col(pk(11'd6, 11'd5), 1, 1);
    step(0, '0, 0, 0, acc);
    check("t5_err_set", err_last, 1);
    send_col(pk(11'd8, 11'd7), 1, 1);
    step(0, '0, 0, 1, acc);
    check("t5_row0", m_data, pk(11'd7, 11'd5));
    drain();
    check("t5_err_sticky", err_last, 1);
    reset_a();
    check("t5_err_cleared", err_last, 0);

    // 6: async reset mid-tile with a full tile pending
    for (int i = 0; i < C + 1; i++) send_col(R*WY'(300 + i), (i % C) == C - 1, 0);
    step(0, '0, 0, 0, acc);
    check("t6_pending", m_valid, 1);
    #2 rstn = 0;
    #1;
    check("t6_valid_drop", m_valid, 0);
    check("t6_ready_drop", s_ready, 0);
    col_n = 0; occ = 0; exp_q.delete();
    @(negedge clk);
    rstn = 1;
    send_col(pk(11'd22, 11'd11), 0, 1);
    send_col(pk(11'd44, 11'd33), 1, 1);
    step(0, '0, 0, 1, acc);
    check("t6_row0", m_data, pk(11'd33, 11'd11));
    drain();

    // 6b: same with R=4, C=3, WY=16
    @(negedge clk);
    b_rstn = 1;
    b_m_ready = 1;
    b_send({4{16'h1111}}, 0);
    #2 b_rstn = 0;
    #1;
    check("b_rst_valid", b_m_valid, 0);
    check("b_rst_ready", b_s_ready, 0);
    @(negedge clk);
    b_rstn = 1;
    for (int c = 0; c < C2; c++) begin
      for (int r = 0; r < R2; r++) bd[r*WY2 +: WY2] = yb(r, c);
      b_send(bd, c == C2 - 1);
    end
    for (int r = 0; r < R2; r++) begin
      #1;
      for (int c = 0; c < C2; c++) be[c*WY2 +: WY2] = yb(r, c);
      check("b_valid", b_m_valid, 1);
      check("b_row", b_m_data, be);
      check("b_last", b_m_last, r == R2 - 1);
      @(negedge clk);
    end
    #1;
    check("b_idle", b_m_valid, 0);
    check("b_err", b_err_last, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
